johnson_decoder: RTL and testbench
==================================

Name: johnson_decoder

Overview:
- Downstream consumer of the 6-stage twisted-ring (Johnson) shift register.
- Samples the ring word, decodes it to a binary phase index 0..11, and flags illegal code words.
- Checks that successive samples advance by exactly one step, and counts full revolutions.
- Feeds phase/sequencing logic that needs a compact binary count instead of the 6-bit ring word.

Parameters:
- STAGES, 6, number of ring flip-flops; the ring has 2*STAGES legal states.
- IDXW, 4, width of index output; must satisfy 2^IDXW >= 2*STAGES.
- CNTW, 8, width of the revolution counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous reset, active-low: clear=0 at a rising edge resets the block.
- en  input  1  sample strobe; 1 = ring shifted this cycle, capture jq.
- jq  input  STAGES  ring word; bit0 = first stage (q1), bit STAGES-1 = last stage (q6).
- index  output  IDXW  decoded phase of last legal sample.
- valid  output  1  one-cycle pulse: a sample was processed last cycle.
- illegal  output  1  one-cycle pulse with valid: last sample was not a legal Johnson word.
- seq_err  output  1  sticky: a legal sample did not follow its predecessor.
- sync  output  1  one-cycle pulse with valid: last sample decoded to index 0.
- revs  output  CNTW  completed revolutions (legal 11->0 transitions).

Behaviour:
- Reset (clear=0 at rising edge): all outputs are 0 and the have_prev flag is cleared. Reset has priority over en in the same cycle. Reset mid-stream discards any in-flight sample.
- Legal words, with k ones/zeros filled from bit0:
  - Index k, for k = 0..STAGES: the low k bits are 1 and the rest are 0.
  - Index STAGES+k, for k = 1..STAGES-1: the low k bits are 0 and the rest are 1.
- Decode rule:
  - msb=0: index = popcount(jq).
  - msb=1: index = 2*STAGES - popcount(jq).
  - The word is legal only if it equals the canonical pattern for that index.
- Latency: exactly 1 cycle. A sample with en=1 at edge N produces valid=1 and its results at edge N+1.
  - valid, illegal and sync are 0 in every cycle not following an en sample.
  - en held high processes every cycle back-to-back.
- Legal sample:
  - index updates.
  - sync=1 if index is 0.
  - If have_prev=1 and new index != (prev_index+1) mod 2*STAGES, set seq_err.
  - If prev_index = 2*STAGES-1 and new index = 0, with have_prev=1, revs increments.
  - have_prev is then set.
- Illegal sample:
  - illegal=1.
  - index holds its previous value.
  - have_prev is cleared, so the next legal sample restarts sequence checking without raising seq_err.
  - revs unchanged.
- Repeated identical legal sample (ring stalled while en=1) sets seq_err.
- seq_err stays 1 until reset; further errors have no extra effect.
- revs wraps modulo 2^CNTW (255 -> 0), with no saturation.
- First legal sample after reset never sets seq_err and never increments revs, even if it is index 0.
- en=0 cycles are ignored and do not break sequence continuity.

Test Plan:
- Reset then walk the full ring with en=1 every cycle, jq = 000000, 000001, 000011, 000111, 001111, 011111, 111111, 111110, 111100, 111000, 110000, 100000, 000000 -> index 0..11 then 0, each one cycle after its sample; sync on the 1st and 13th samples; revs=1; seq_err=0; illegal never.
- Inject jq=010101 mid-walk after index 4 -> illegal=1 for one cycle, index stays 4. Next sample 011111 -> index 5, seq_err stays 0.
- Skip a state: samples 000011 then 001111 -> index 2 then 4, seq_err=1. It remains 1 after 20 further correct samples.
- Stalled ring: 000111 sampled twice -> seq_err=1 at the second result.
- Gap test: 000001, en=0 for 5 cycles, then 000011 -> no error, index 2.
- Reset mid-stream and overflow:
  - Assert clear=0 during an en=1 sample -> next cycle all outputs are 0.
  - First sample 100000 -> index 11, no error.
  - Drive 256 revolutions -> revs returns to 0.

Source files
------------

// File: rtl/johnson_decoder.sv
`default_nettype none
// ============================================================================
// Module      : johnson_decoder
// Description : Samples a twisted-ring (Johnson) counter word, decodes it to a
//               binary phase index 0..2*STAGES-1, flags illegal code words,
//               checks that successive legal samples advance by exactly one
//               step, and counts completed revolutions (last phase -> 0).
//
// Ports       : clk      - system clock, rising edge
//               clear    - synchronous reset, active low
//               en       - sample strobe, capture jq this cycle
//               jq       - ring word, bit0 = first stage
//               index    - phase of the last legal sample
//               valid    - pulse: a sample was processed last cycle
//               illegal  - pulse: last sample was not a legal Johnson word
//               seq_err  - sticky: a legal sample did not follow its predecessor
//               sync     - pulse: last sample decoded to phase 0
//               revs     - completed revolutions, wraps modulo 2^CNTW
//
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_decoder #(
    parameter int STAGES = 6,
    parameter int IDXW   = 4,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              en,
    input  logic [STAGES-1:0] jq,
    output logic [IDXW-1:0]   index,
    output logic              valid,
    output logic              illegal,
    output logic              seq_err,
    output logic              sync,
    output logic [CNTW-1:0]   revs
);

    localparam int              RING     = 2 * STAGES;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RING - 1);

    // The index output must be able to represent every ring phase.
    if ((1 << IDXW) < RING) begin : g_idxw_check
        $error("johnson_decoder: IDXW too small for 2*STAGES phases");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDXW-1:0] index_q,     index_d;
    logic            valid_q,     valid_d;
    logic            illegal_q,   illegal_d;
    logic            seq_err_q,   seq_err_d;
    logic            sync_q,      sync_d;
    logic [CNTW-1:0] revs_q,      revs_d;
    logic            have_prev_q, have_prev_d;

    // ------------------------------------------------------------------
    // Word decode
    // The ones count alone gives the phase once the msb says which half of
    // the ring we are in; legality is then a compare against the single
    // canonical pattern for that phase.
    // ------------------------------------------------------------------
    logic [IDXW-1:0]   w_dec_idx;
    logic              w_dec_legal;
    logic [STAGES-1:0] w_canon;
    int                w_ones;

    always_comb begin
        w_ones = 0;
        for (int i = 0; i < STAGES; i++) begin
            if (jq[i]) begin
                w_ones = w_ones + 1;
            end
        end

        w_canon = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (jq[STAGES-1]) begin
                // Second half: low (STAGES-ones) bits zero, rest ones.
                w_canon[i] = (i >= (STAGES - w_ones));
            end else begin
                // First half: low 'ones' bits set, rest zero.
                w_canon[i] = (i < w_ones);
            end
        end

        if (jq[STAGES-1]) begin
            w_dec_idx = IDXW'(RING - w_ones);
        end else begin
            w_dec_idx = IDXW'(w_ones);
        end

        w_dec_legal = (jq == w_canon);
    end

    // Phase expected to follow the previously accepted one.
    logic [IDXW-1:0] w_succ;
    assign w_succ = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        index_d     = index_q;
        valid_d     = 1'b0;
        illegal_d   = 1'b0;
        sync_d      = 1'b0;
        seq_err_d   = seq_err_q;
        revs_d      = revs_q;
        have_prev_d = have_prev_q;

        if (en) begin
            valid_d = 1'b1;
            if (w_dec_legal) begin
                index_d     = w_dec_idx;
                sync_d      = (w_dec_idx == '0);
                have_prev_d = 1'b1;
                // Without a trusted predecessor there is nothing to compare
                // against, so neither the step check nor the wrap count apply.
                if (have_prev_q) begin
                    if (w_dec_idx != w_succ) begin
                        seq_err_d = 1'b1;
                    end
                    if ((index_q == LAST_IDX) && (w_dec_idx == '0)) begin
                        revs_d = revs_q + 1'b1;
                    end
                end
            end else begin
                // Index holds; continuity restarts at the next legal word.
                illegal_d   = 1'b1;
                have_prev_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clear) begin
            index_q     <= '0;
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            sync_q      <= 1'b0;
            revs_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            index_q     <= index_d;
            valid_q     <= valid_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
            sync_q      <= sync_d;
            revs_q      <= revs_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign index   = index_q;
    assign valid   = valid_q;
    assign illegal = illegal_q;
    assign seq_err = seq_err_q;
    assign sync    = sync_q;
    assign revs    = revs_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_johnson_decoder
// Description : Self-checking bench for johnson_decoder. A phase-table model
//               predicts every output each cycle; directed scenarios pin the
//               model with hand-computed values, then randomized traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_decoder;

    localparam int STAGES = 6;
    localparam int IDXW   = 4;
    localparam int CNTW   = 8;
    localparam int RING   = 2 * STAGES;

    logic              clk = 1'b0;
    logic              clear = 1'b0;
    logic              en = 1'b0;
    logic [STAGES-1:0] jq = '0;
    logic [IDXW-1:0]   index;
    logic              valid, illegal, seq_err, sync;
    logic [CNTW-1:0]   revs;

    johnson_decoder #(.STAGES(STAGES), .IDXW(IDXW), .CNTW(CNTW)) dut (
        .clk     (clk),
        .clear   (clear),
        .en      (en),
        .jq      (jq),
        .index   (index),
        .valid   (valid),
        .illegal (illegal),
        .seq_err (seq_err),
        .sync    (sync),
        .revs    (revs)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Legal ring words indexed by phase, built from the fill rule.
    logic [STAGES-1:0] tbl [RING];

    function automatic int lookup(input logic [STAGES-1:0] w);
        for (int k = 0; k < RING; k++) begin
            if (tbl[k] == w) return k;
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Reference model + per-cycle compare
    // ------------------------------------------------------------------
    int                m_index = 0, m_revs = 0, m_k;
    bit                m_hp = 0, m_seq = 0, m_valid = 0, m_illegal = 0, m_sync = 0;
    bit                checking = 0;
    logic              s_clear, s_en;
    logic [STAGES-1:0] s_jq;

    always @(posedge clk) begin
        s_clear = clear;
        s_en    = en;
        s_jq    = jq;
        if (!s_clear) begin
            m_index = 0; m_revs = 0; m_hp = 0; m_seq = 0;
            m_valid = 0; m_illegal = 0; m_sync = 0;
            checking = 1;
        end else if (s_en) begin
            m_k     = lookup(s_jq);
            m_valid = 1;
            if (m_k >= 0) begin
                m_illegal = 0;
                m_sync    = (m_k == 0);
                if (m_hp && m_k != (m_index + 1) % RING) m_seq = 1;
                if (m_hp && m_index == RING - 1 && m_k == 0) m_revs = (m_revs + 1) % (1 << CNTW);
                m_index = m_k;
                m_hp    = 1;
            end else begin
                m_illegal = 1;
                m_sync    = 0;
                m_hp      = 0;
            end
        end else begin
            m_valid = 0; m_illegal = 0; m_sync = 0;
        end
        #1;
        if (checking) begin
            chk("mdl_index",   int'(index),   m_index);
            chk("mdl_valid",   int'(valid),   int'(m_valid));
            chk("mdl_illegal", int'(illegal), int'(m_illegal));
            chk("mdl_seq_err", int'(seq_err), int'(m_seq));
            chk("mdl_sync",    int'(sync),    int'(m_sync));
            chk("mdl_revs",    int'(revs),    m_revs);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive on falling edge, look 1 after rising edge)
    // ------------------------------------------------------------------
    task automatic step(input logic [STAGES-1:0] w);
        @(negedge clk);
        clear = 1'b1; en = 1'b1; jq = w;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        @(negedge clk);
        clear = 1'b1; en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear = 1'b0; en = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [STAGES-1:0] walk [13] = '{6'b000000, 6'b000001, 6'b000011, 6'b000111,
                                     6'b001111, 6'b011111, 6'b111111, 6'b111110,
                                     6'b111100, 6'b111000, 6'b110000, 6'b100000,
                                     6'b000000};
    int cur;
    int sel;

    initial begin
        for (int k = 0; k <= STAGES; k++) tbl[k] = STAGES'((1 << k) - 1);
        for (int k = 1; k < STAGES; k++)  tbl[STAGES + k] = ~STAGES'((1 << k) - 1);

        // Reset state
        do_reset();
        chk("rst_index", int'(index), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_revs",  int'(revs),  0);

        // Full walk
        for (int i = 0; i < 13; i++) begin
            step(walk[i]);
            chk("walk_index", int'(index), i % RING);
            chk("walk_sync",  int'(sync),  (i == 0 || i == 12) ? 1 : 0);
            chk("walk_valid", int'(valid), 1);
        end
        chk("walk_revs",    int'(revs),    1);
        chk("walk_seq_err", int'(seq_err), 0);

        // Illegal word mid-walk
        for (int i = 1; i <= 4; i++) step(walk[i]);
        step(6'b010101);
        chk("ill_flag",  int'(illegal), 1);
        chk("ill_index", int'(index),   4);
        step(6'b011111);
        chk("ill_next_index", int'(index),   5);
        chk("ill_next_seq",   int'(seq_err), 0);
        chk("ill_next_flag",  int'(illegal), 0);

        // Skipped state, then sticky
        do_reset();
        step(6'b000011);
        chk("skip_first", int'(seq_err), 0);
        step(6'b001111);
        chk("skip_index", int'(index),   4);
        chk("skip_seq",   int'(seq_err), 1);
        for (int i = 0; i < 20; i++) step(tbl[(5 + i) % RING]);
        chk("skip_sticky", int'(seq_err), 1);

        // Stalled ring
        do_reset();
        step(6'b000111);
        chk("stall_first", int'(seq_err), 0);
        step(6'b000111);
        chk("stall_second", int'(seq_err), 1);

        // Gap in en
        do_reset();
        step(6'b000001);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("gap_valid", int'(valid), 0);
        end
        step(6'b000011);
        chk("gap_index", int'(index),   2);
        chk("gap_seq",   int'(seq_err), 0);

        // Reset during a sample
        step(6'b000111);
        @(negedge clk);
        clear = 1'b0; en = 1'b1; jq = 6'b001111;
        @(posedge clk); #1;
        chk("mid_rst_index", int'(index), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_seq",   int'(seq_err), 0);

        // First sample at phase 11, then 256 revolutions
        step(6'b100000);
        chk("first11_index", int'(index),   11);
        chk("first11_seq",   int'(seq_err), 0);
        chk("first11_revs",  int'(revs),    0);
        for (int r = 0; r < 256; r++) begin
            for (int k = 0; k < RING; k++) step(tbl[k]);
            if (r == 127) chk("revs_128", int'(revs), 128);
        end
        chk("revs_wrap", int'(revs),    0);
        chk("wrap_seq",  int'(seq_err), 0);

        // Randomized traffic
        do_reset();
        cur = 0;
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            clear = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
            en    = ($urandom_range(99) < 80) ? 1'b1 : 1'b0;
            sel   = int'($urandom_range(99));
            if (sel < 70) begin
                cur = (cur + 1) % RING;
                jq  = tbl[cur];
            end else if (sel < 80) begin
                jq = tbl[cur];
            end else if (sel < 90) begin
                cur = int'($urandom_range(RING - 1));
                jq  = tbl[cur];
            end else begin
                jq = STAGES'($urandom);
            end
        end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #2;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
